// File: rtl/n4_b3_to_bin_converter.sv
// Converts a 4-digit base-3 counter snapshot into unsigned binary by serial
// Horner evaluation (MS digit first, one digit per clock), with valid/ready on both sides.
module n4_b3_to_bin_converter #(
    parameter int OUT_W        = 7,
    parameter int CHECK_DIGITS = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       q31_q30,
    input  logic [1:0]       q21_q20,
    input  logic [1:0]       q11_q10,
    input  logic [1:0]       q01_q00,
    input  logic             eu_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] bin,
    output logic             carry_out,
    output logic             err,
    output logic [1:0]       dbg_state_o
);

    // Handshake: a transfer happens on a posedge where valid and ready are both 1.
    // in_ready is high only in IDLE and out_valid only in DONE, so in_valid
    // outside IDLE and out_ready outside DONE have no effect.
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CONV = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [3:0][1:0]  digits_q, digits_d;
    logic [1:0]       idx_q, idx_d;
    logic [OUT_W-1:0] acc_q, acc_d;
    logic [OUT_W-1:0] bin_q, bin_d;
    logic             carry_q, carry_d;
    logic             err_q, err_d;

    logic [3:0][1:0]  raw_digits;
    logic [3:0][1:0]  cap_digits;
    logic             cap_err;
    logic [OUT_W-1:0] next_acc;

    assign raw_digits = {q31_q30, q21_q20, q11_q10, q01_q00};

    // Illegal code 2'b11 is flagged and folded to 0 only when checking is enabled.
    always_comb begin
        cap_digits = raw_digits;
        cap_err    = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if ((CHECK_DIGITS != 0) && (raw_digits[i] == 2'b11)) begin
                cap_err       = 1'b1;
                cap_digits[i] = 2'b00;
            end
        end
    end

    // 3*acc computed as (acc<<1)+acc to avoid a multiplier.
    assign next_acc = (acc_q << 1) + acc_q + OUT_W'(digits_q[idx_q]);

    always_comb begin
        state_d  = state_q;
        digits_d = digits_q;
        idx_d    = idx_q;
        acc_d    = acc_q;
        bin_d    = bin_q;
        carry_d  = carry_q;
        err_d    = err_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    digits_d = cap_digits;
                    carry_d  = eu_in;
                    err_d    = cap_err;
                    acc_d    = '0;
                    idx_d    = 2'd3;
                    state_d  = ST_CONV;
                end
            end
            ST_CONV: begin
                acc_d = next_acc;
                idx_d = idx_q - 2'd1;
                if (idx_q == 2'd0) begin
                    bin_d   = next_acc;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            digits_q <= '0;
            idx_q    <= 2'd0;
            acc_q    <= '0;
            bin_q    <= '0;
            carry_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            digits_q <= digits_d;
            idx_q    <= idx_d;
            acc_q    <= acc_d;
            bin_q    <= bin_d;
            carry_q  <= carry_d;
            err_q    <= err_d;
        end
    end

    assign in_ready    = (state_q == ST_IDLE);
    assign out_valid   = (state_q == ST_DONE);
    assign bin         = bin_q;
    assign carry_out   = carry_q;
    assign err         = err_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_n4_b3_to_bin_converter.sv
// Bench for n4_b3_to_bin_converter: one instance with digit checking, one without,
// driven in parallel; a scoreboard queue holds the expected results of both.
module tb_n4_b3_to_bin_converter;

    logic       clock;
    logic       reset;
    logic       in_valid;
    logic [1:0] d3, d2, d1, d0;
    logic       eu_in;
    logic       out_ready;

    logic       in_ready_c, out_valid_c, carry_c, err_c;
    logic [6:0] bin_c;
    logic [1:0] state_c;
    logic       in_ready_n, out_valid_n, carry_n, err_n;
    logic [6:0] bin_n;
    logic [1:0] state_n;

    int checks = 0;
    int errors = 0;

    // {carry, err_c, bin_c[6:0], err_n, bin_n[6:0]}
    logic [16:0] exp_q[$];

    n4_b3_to_bin_converter #(.OUT_W(7), .CHECK_DIGITS(1)) u_dut_c (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_c),
        .q31_q30(d3), .q21_q20(d2), .q11_q10(d1), .q01_q00(d0), .eu_in(eu_in),
        .out_valid(out_valid_c), .out_ready(out_ready), .bin(bin_c),
        .carry_out(carry_c), .err(err_c), .dbg_state_o(state_c)
    );

    n4_b3_to_bin_converter #(.OUT_W(7), .CHECK_DIGITS(0)) u_dut_n (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_n),
        .q31_q30(d3), .q21_q20(d2), .q11_q10(d1), .q01_q00(d0), .eu_in(eu_in),
        .out_valid(out_valid_n), .out_ready(out_ready), .bin(bin_n),
        .carry_out(carry_n), .err(err_n), .dbg_state_o(state_n)
    );

    // Clock / reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: pops one expected entry per output handshake.
    always @(negedge clock) begin
        logic [16:0] e;
        if (!reset && (out_valid_c || out_valid_n) && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output bin_c=%0d bin_n=%0d", bin_c, bin_n);
            end else begin
                e = exp_q.pop_front();
                chk("result_check_on", int'({out_valid_c, carry_c, err_c, bin_c}),
                    int'({1'b1, e[16:8]}));
                chk("result_check_off", int'({out_valid_n, carry_n, err_n, bin_n}),
                    int'({1'b1, e[16], e[7:0]}));
            end
        end
    end

    // Driver: one snapshot through accept, conversion, optional back-pressure, ack.
    task automatic send(input logic [1:0] a3, input logic [1:0] a2, input logic [1:0] a1,
                        input logic [1:0] a0, input logic eu, input int eb_c,
                        input logic ee_c, input int eb_n, input int hold, input logic noise);
        int n;
        n = 0;
        while (!in_ready_c && n < 50) begin
            @(posedge clock); #1;
            n++;
        end
        chk("in_ready_before_accept", int'(in_ready_c), 1);
        in_valid = 1'b1;
        {d3, d2, d1, d0} = {a3, a2, a1, a0};
        eu_in = eu;
        @(posedge clock); #1;
        exp_q.push_back({eu, ee_c, 7'(eb_c), 1'b0, 7'(eb_n)});
        if (noise) begin
            {d3, d2, d1, d0} = {2'd2, 2'd2, 2'd2, 2'd2};
            eu_in = ~eu;
        end else begin
            in_valid = 1'b0;
        end
        n = 0;
        do begin
            @(posedge clock); #1;
            n++;
            if (n == 3) in_valid = 1'b0;
        end while (!out_valid_c && n < 20);
        chk("latency", n, 4);
        chk("in_ready_low_in_done", int'(in_ready_c), 0);
        for (int i = 0; i < hold; i++) begin
            @(posedge clock); #1;
            chk("hold_valid_ready_bin", int'({out_valid_c, in_ready_c, bin_c}),
                int'({1'b1, 1'b0, 7'(eb_c)}));
        end
        out_ready = 1'b1;
        @(posedge clock); #1;
        out_ready = 1'b0;
        chk("idle_after_ack", int'({in_ready_c, out_valid_c}), 2);
    endtask

    initial begin
        int seen;
        reset = 1'b1;
        in_valid = 1'b0;
        {d3, d2, d1, d0} = '0;
        eu_in = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        chk("reset_in_ready", int'(in_ready_c), 1);
        chk("reset_out_valid", int'(out_valid_c), 0);
        chk("reset_bin", int'(bin_c), 0);
        chk("reset_carry_err", int'({carry_c, err_c}), 0);
        chk("reset_state", int'(state_c), 0);
        reset = 1'b0;
        @(posedge clock); #1;

        // digits          eu    bin_c err_c bin_n hold noise
        send(2'd0, 2'd0, 2'd0, 2'd0, 1'b0,  0, 1'b0,  0,  0, 1'b0);
        send(2'd2, 2'd2, 2'd2, 2'd2, 1'b1, 80, 1'b0, 80,  0, 1'b0);
        send(2'd1, 2'd0, 2'd1, 2'd2, 1'b0, 32, 1'b0, 32, 10, 1'b0);
        send(2'd3, 2'd0, 2'd0, 2'd1, 1'b0,  1, 1'b1, 82,  2, 1'b0);
        send(2'd0, 2'd1, 2'd2, 2'd1, 1'b0, 16, 1'b0, 16,  0, 1'b1);
        send(2'd2, 2'd1, 2'd0, 2'd3, 1'b1, 63, 1'b1, 66,  1, 1'b0);

        // Reset on the second conversion edge discards the result.
        in_valid = 1'b1;
        {d3, d2, d1, d0} = {2'd2, 2'd2, 2'd2, 2'd2};
        eu_in = 1'b1;
        @(posedge clock); #1;
        in_valid = 1'b0;
        @(posedge clock); #1;
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        chk("midreset_in_ready", int'(in_ready_c), 1);
        chk("midreset_out_valid", int'(out_valid_c), 0);
        chk("midreset_bin", int'(bin_c), 0);
        chk("midreset_carry_err", int'({carry_c, err_c}), 0);
        out_ready = 1'b1;
        seen = 0;
        repeat (8) begin
            @(posedge clock); #1;
            if (out_valid_c || out_valid_n) seen++;
        end
        out_ready = 1'b0;
        chk("no_spurious_valid", seen, 0);

        send(2'd1, 2'd1, 2'd1, 2'd1, 1'b1, 40, 1'b0, 40, 0, 1'b0);

        repeat (3) @(posedge clock);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
